shiftreg_loader: RTL

SHIFTREG_LOADER -- requirements
Module: shiftreg_loader

---
 rtl/shiftreg_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/shiftreg_loader.sv
// Serial configuration loader: shifts an N-bit frame MSB first on a divided sclk,
// captures the far-end readback from sr_out, then pulses latch to commit the frame.
module shiftreg_loader #(
  parameter int N      = 59,
  parameter int CLKDIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] data,
  input  logic         sr_out,
  output logic         sclk,
  output logic         sdin,
  output logic         latch,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rdata
);

  localparam int DW = $clog2(CLKDIV + 1);
  localparam int BW = $clog2(N);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [BW-1:0] IDX_TOP  = BW'(N - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    LATCH,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [DW-1:0]  div;
  logic [BW-1:0]  bit_cnt;
  logic [N-1:0]   shadow;
  logic           phase_end;
  logic           last_bit;

  assign phase_end = (div == DIV_LAST);
  assign last_bit  = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOW;
      LOW:     if (phase_end) state_next = HIGH;
      HIGH:    if (phase_end) state_next = last_bit ? LATCH : LOW;
      LATCH:   if (phase_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered copies of the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk    <= 1'b0;
      sdin    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      shadow  <= '0;
      div     <= '0;
      bit_cnt <= '0;
    end else begin
      sclk  <= (state_next == HIGH);
      latch <= (state_next == LATCH);
      busy  <= (state_next inside {LOW, HIGH, LATCH});
      done  <= (state_next == DONE);

      if ((state != state_next) || (state == IDLE)) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= data;
            sdin    <= data[N-1];
            bit_cnt <= '0;
          end
        end
        // Readback is sampled on the edge sclk rises, before the far end shifts.
        LOW: begin
          if (phase_end) begin
            rdata <= {rdata[N-2:0], sr_out};
          end
        end
        HIGH: begin
          if (phase_end) begin
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 1'b1;
              sdin    <= shadow[IDX_TOP - bit_cnt];
            end else begin
              sdin <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
